// File: rtl/rtc_pkg.sv
// Shared types and constants for the battery-backed clock / parameter RAM controller.
package rtc_pkg;

  typedef enum logic [1:0] {ST_CMD, ST_ADDR2, ST_DATA} state_t;
  typedef enum logic [1:0] {TGT_CLK, TGT_WP, TGT_TEST, TGT_BRAM} target_t;

  localparam logic [6:0] CMD_WP     = 7'h35;
  localparam logic [6:0] CMD_TEST   = 7'h31;
  localparam logic [3:0] EXT_PREFIX = 4'b0111;

  localparam int START = 7;
  localparam int DIR   = 6;
  localparam int LAST  = 5;

  function automatic logic is_clock_cmd(input logic [7:0] cmd);
    return (cmd[6:4] == 3'b000) && (cmd[1:0] == 2'b01);
  endfunction

  function automatic logic is_bram_cmd(input logic [7:0] cmd);
    return cmd[6] && (cmd[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/rtc_bram_array.sv
// 256x8 battery RAM: synchronous write, asynchronous read, deliberately no reset.
module rtc_bram_array
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/rtc_bram.sv
// Clock/parameter-RAM controller behind the $C033 data / $C034 control strobe pair.
//   state    | meaning
//   ST_CMD   | data holds a command byte to decode
//   ST_ADDR2 | extended command: data holds the low address bits
//   ST_DATA  | next transfer reads or writes the selected byte
module rtc_bram
  import rtc_pkg::*;
#(
  parameter int CEN_HZ      = 2500000,
  parameter int XFER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       strobe,
  input  logic       rw,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam int PW = $clog2(CEN_HZ);
  localparam int XW = $clog2(XFER_CYCLES + 1);

  state_t        state, state_nxt;
  target_t       tgt, tgt_nxt;
  logic [7:0]    data, data_nxt;
  logic [6:0]    ctrl, ctrl_nxt;
  logic          busy, busy_nxt;
  logic [XW-1:0] xfer_cnt, xfer_nxt;
  logic [7:0]    wp, wp_nxt;
  logic [7:0]    test, test_nxt;
  logic [PW-1:0] prescaler, presc_nxt;
  logic [31:0]   seconds, sec_nxt;
  logic          cmd_rd, cmd_rd_nxt;
  logic [1:0]    clk_sel, clk_sel_nxt;
  logic [7:0]    sel_addr, sel_addr_nxt;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic [7:0]    sel_byte;
  logic          tick;

  rtc_bram_array u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (sel_addr),
    .wdata (data),
    .rdata (ram_rdata)
  );

  assign dout = addr ? data : {busy, ctrl};
  assign tick = cen && (prescaler == PW'(CEN_HZ - 1));

  always_comb begin
    sel_byte = ram_rdata;
    case (tgt)
      TGT_CLK:  sel_byte = seconds[{clk_sel, 3'b000} +: 8];
      TGT_WP:   sel_byte = wp;
      TGT_TEST: sel_byte = test;
      default:  sel_byte = ram_rdata;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt;
    data_nxt     = data;
    ctrl_nxt     = ctrl;
    busy_nxt     = busy;
    xfer_nxt     = xfer_cnt;
    wp_nxt       = wp;
    test_nxt     = test;
    cmd_rd_nxt   = cmd_rd;
    clk_sel_nxt  = clk_sel;
    sel_addr_nxt = sel_addr;
    ram_we       = 1'b0;
    presc_nxt    = prescaler;
    sec_nxt      = seconds;

    if (cen) presc_nxt = tick ? '0 : prescaler + 1'b1;
    if (tick) sec_nxt = seconds + 32'd1;

    if (strobe && !rw && addr && !busy) data_nxt = din;
    if (strobe && !rw && !addr) begin
      ctrl_nxt = din[6:0];
      if (din[START] && !busy) begin
        busy_nxt = 1'b1;
        xfer_nxt = XW'(XFER_CYCLES - 1);
      end
    end

    if (busy && cen) begin
      if (xfer_cnt != '0) begin
        xfer_nxt = xfer_cnt - 1'b1;
      end else begin
        busy_nxt = 1'b0;
        case (state)
          ST_CMD: begin
            cmd_rd_nxt = data[7];
            if (is_clock_cmd(data)) begin
              tgt_nxt     = TGT_CLK;
              clk_sel_nxt = data[3:2];
              state_nxt   = ST_DATA;
            end else if (data[6:0] == CMD_WP) begin
              tgt_nxt   = TGT_WP;
              state_nxt = ST_DATA;
            end else if (data[6:0] == CMD_TEST) begin
              tgt_nxt   = TGT_TEST;
              state_nxt = ST_DATA;
            end else if (is_bram_cmd(data)) begin
              tgt_nxt      = TGT_BRAM;
              sel_addr_nxt = {4'h0, data[5:2]};
              state_nxt    = ST_DATA;
            end else if (data[6:3] == EXT_PREFIX) begin
              tgt_nxt           = TGT_BRAM;
              sel_addr_nxt[7:5] = data[2:0];
              state_nxt         = ST_ADDR2;
            end
          end
          ST_ADDR2: begin
            sel_addr_nxt = {sel_addr[7:5], data[6:2]};
            state_nxt    = ST_DATA;
          end
          default: begin
            if (cmd_rd) begin
              if (ctrl[DIR]) data_nxt = sel_byte;
            end else if (!ctrl[DIR]) begin
              // write-protect only guards clock, test and BRAM; WP stays writable
              case (tgt)
                TGT_WP:   wp_nxt = data;
                TGT_CLK:  if (!wp[7]) sec_nxt[{clk_sel, 3'b000} +: 8] = data;
                TGT_TEST: if (!wp[7]) test_nxt = data;
                default:  ram_we = !wp[7];
              endcase
            end
            state_nxt = ST_CMD;
          end
        endcase
        if (ctrl[LAST]) state_nxt = ST_CMD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CMD;
      tgt       <= TGT_CLK;
      data      <= '0;
      ctrl      <= '0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
      wp        <= '0;
      test      <= '0;
      prescaler <= '0;
      seconds   <= '0;
      cmd_rd    <= 1'b0;
      clk_sel   <= '0;
      sel_addr  <= '0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      data      <= data_nxt;
      ctrl      <= ctrl_nxt;
      busy      <= busy_nxt;
      xfer_cnt  <= xfer_nxt;
      wp        <= wp_nxt;
      test      <= test_nxt;
      prescaler <= presc_nxt;
      seconds   <= sec_nxt;
      cmd_rd    <= cmd_rd_nxt;
      clk_sel   <= clk_sel_nxt;
      sel_addr  <= sel_addr_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_bram.sv
// Directed-vector bench for rtc_bram: protocol, write protect, extended addressing, busy timing, seconds wrap, abort.
module tb_rtc_bram;

  localparam int CEN_HZ = 200;
  localparam int XFER   = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cen = 1'b0;
  logic       strobe = 1'b0;
  logic       rw = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;

  int vectors = 0;
  int errors = 0;
  int cens = 0;

  rtc_bram #(.CEN_HZ(CEN_HZ), .XFER_CYCLES(XFER)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .strobe  (strobe),
    .rw      (rw),
    .addr    (addr),
    .din     (din),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cen = 1'b0; strobe = 1'b0; rw = 1'b0; addr = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cens = 0;
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b0; addr = a; din = v;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [7:0] v);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b1; addr = a;
    #1 v = dout;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0;
  endtask

  task automatic pulse_cen(input int n);
    if (n > 0) begin
      @(negedge clk);
      cen = 1'b1;
      repeat (n) @(negedge clk);
      cen = 1'b0;
      cens += n;
    end
  endtask

  task automatic xfer(input logic [7:0] c);
    int n;
    wr(1'b0, c);
    addr = 1'b0;
    #1;
    n = 0;
    cen = 1'b1;
    while (dout[7] && n < 64) begin
      @(negedge clk);
      n++;
    end
    cen = 1'b0;
    cens += n;
    if (n >= 64) begin
      vectors++; errors++;
      $display("FAIL xfer_timeout: busy still set after %0d cen pulses, required clear after %0d", n, XFER);
    end
  endtask

  task automatic put(input logic [7:0] b);
    wr(1'b1, b);
    xfer(8'h80);
  endtask

  task automatic get(output logic [7:0] v);
    xfer(8'hC0);
    rd(1'b1, v);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    rd(1'b0, v); vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %02h expected 00", v); end
    rd(1'b1, v); vectors++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", v); end
    pulse_cen(2 * CEN_HZ);
    put(8'h81); get(v); vectors++;
    if (v !== 8'h02) begin errors++; $display("FAIL seconds_after_2s: got %02h expected 02", v); end
  endtask

  task automatic test_write_protect();
    logic [7:0] v;
    put(8'h41); put(8'h11);
    put(8'h35); put(8'h80);
    put(8'hB5); get(v); vectors++;
    if (v !== 8'h80) begin errors++; $display("FAIL wp_readback: got %02h expected 80", v); end
    put(8'h41); put(8'h5A);
    put(8'hC1); get(v); vectors++;
    if (v !== 8'h11) begin errors++; $display("FAIL wp_blocks_bram: got %02h expected 11", v); end
    put(8'h35); put(8'h00);
    put(8'h41); put(8'h5A);
    put(8'hC1); get(v); vectors++;
    if (v !== 8'h5A) begin errors++; $display("FAIL bram_write_unprotected: got %02h expected 5A", v); end
  endtask

  task automatic test_extended();
    logic [7:0] v;
    put(8'h3F); put(8'h7C); put(8'hA5);
    put(8'hBF); put(8'h7C); get(v); vectors++;
    if (v !== 8'hA5) begin errors++; $display("FAIL ext_bram_ff: got %02h expected A5", v); end
    put(8'hC1); get(v); vectors++;
    if (v !== 8'h5A) begin errors++; $display("FAIL ext_no_alias_00: got %02h expected 5A", v); end
  endtask

  task automatic test_busy();
    logic [7:0] v;
    wr(1'b1, 8'h5A);
    wr(1'b0, 8'h80);
    pulse_cen(5);
    rd(1'b0, v); vectors++;
    if (v !== 8'h80) begin errors++; $display("FAIL busy_after_5: got %02h expected 80", v); end
    wr(1'b0, 8'h83);
    rd(1'b0, v); vectors++;
    if (v !== 8'h83) begin errors++; $display("FAIL ctrl_update_while_busy: got %02h expected 83", v); end
    wr(1'b1, 8'h77);
    rd(1'b1, v); vectors++;
    if (v !== 8'h5A) begin errors++; $display("FAIL data_write_while_busy: got %02h expected 5A", v); end
    pulse_cen(XFER - 6);
    rd(1'b0, v); vectors++;
    if (v !== 8'h83) begin errors++; $display("FAIL busy_at_15: got %02h expected 83", v); end
    pulse_cen(1);
    rd(1'b0, v); vectors++;
    if (v !== 8'h03) begin errors++; $display("FAIL busy_clear_at_16: got %02h expected 03", v); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    logic [7:0] exp_tick [3];
    logic [7:0] rcmd [4];
    do_reset();
    rcmd[0] = 8'h81; rcmd[1] = 8'h85; rcmd[2] = 8'h89; rcmd[3] = 8'h8D;
    put(8'h01); put(8'hFF);
    put(8'h05); put(8'hFF);
    put(8'h09); put(8'hFF);
    put(8'h0D); put(8'hFF);
    pulse_cen(CEN_HZ - cens);
    for (int i = 0; i < 4; i++) begin
      put(rcmd[i]); get(v); vectors++;
      if (v !== 8'h00) begin errors++; $display("FAIL seconds_wrap_byte%0d: got %02h expected 00", i, v); end
    end
    // clock write of byte1 lands on the same clk as the next tick
    put(8'h05);
    pulse_cen(2 * CEN_HZ - XFER - cens);
    put(8'h12);
    exp_tick[0] = 8'h01; exp_tick[1] = 8'h12; exp_tick[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      put(rcmd[i]); get(v); vectors++;
      if (v !== exp_tick[i]) begin errors++; $display("FAIL tick_collision_byte%0d: got %02h expected %02h", i, v, exp_tick[i]); end
    end
  endtask

  task automatic test_abort_reset();
    logic [7:0] v;
    wr(1'b1, 8'h3F);
    xfer(8'hA0);
    put(8'h81); get(v); vectors++;
    if (v !== 8'h01) begin errors++; $display("FAIL abort_then_cmd: got %02h expected 01", v); end
    wr(1'b0, 8'h80);
    pulse_cen(5);
    rd(1'b0, v); vectors++;
    if (v !== 8'h80) begin errors++; $display("FAIL busy_before_reset: got %02h expected 80", v); end
    @(negedge clk);
    reset_n = 1'b0;
    addr = 1'b0;
    #1; vectors++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_mid_busy_ctrl: got %02h expected 00", dout); end
    addr = 1'b1;
    #1; vectors++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_mid_busy_data: got %02h expected 00", dout); end
    @(negedge clk);
    reset_n = 1'b1;
    cens = 0;
    put(8'hC1); get(v); vectors++;
    if (v !== 8'h5A) begin errors++; $display("FAIL bram_retained: got %02h expected 5A", v); end
  endtask

  initial begin
    test_reset();
    test_write_protect();
    test_extended();
    test_busy();
    test_wrap();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
